icache_setassoc: RTL and testbench

//   Parametrised N-way set-associative, read-only cache with pseudo-LRU replacement and flush.

---
 rtl/icache_setassoc.sv | 202 ++++++++++++++++++++
 tb/tb_icache_setassoc.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_setassoc.sv
// icache_setassoc
//   N-way set-associative read-only cache with tree pseudo-LRU replacement
//   and flush. It sits between a fetch/load port and line-wide main memory.
//   Requests are captured in a register. Only one miss is outstanding at a
//   time. A hit is looked up in the cycle after the request is accepted.
//
//   Ports
//     clk_i, rstn_i      clock, asynchronous active-low reset
//     flush_i            invalidate every line (single-cycle pulse)
//     addr_i, read_en_i  request byte address and request valid
//     ready_o            request accepted on this edge when high
//     read_valid_o       one-cycle pulse that qualifies read_word_o
//     read_word_o        returned word
//     mem_addr_o         line-aligned refill address
//     mem_read_en_o      refill request, held until mem_read_valid_i
//     mem_read_valid_i   refill data strobe
//     mem_read_data_i    refill line, word 0 in the LSBs
module icache_setassoc #(
  parameter int NrWays         = 2,
  parameter int NrSets         = 64,
  parameter int NrWordsPerLine = 4,
  parameter int DataWidth      = 32,
  parameter int AddrWidth      = 32
) (
  input  logic                                clk_i,
  input  logic                                rstn_i,
  input  logic                                flush_i,
  input  logic [AddrWidth-1:0]                addr_i,
  input  logic                                read_en_i,
  output logic                                ready_o,
  output logic                                read_valid_o,
  output logic [DataWidth-1:0]                read_word_o,
  output logic [AddrWidth-1:0]                mem_addr_o,
  output logic                                mem_read_en_o,
  input  logic                                mem_read_valid_i,
  input  logic [NrWordsPerLine*DataWidth-1:0] mem_read_data_i
);

  localparam int ByteBits = $clog2(DataWidth/8);
  localparam int OffBits  = $clog2(NrWordsPerLine*DataWidth/8);
  localparam int IdxBits  = $clog2(NrSets);
  localparam int TagBits  = AddrWidth - IdxBits - OffBits;
  localparam int LineW    = NrWordsPerLine * DataWidth;
  localparam int LogWays  = $clog2(NrWays);
  localparam int WayW     = (LogWays > 0) ? LogWays : 1;
  localparam int PlruW    = (NrWays > 1) ? NrWays - 1 : 1;
  localparam int WordW    = (OffBits > ByteBits) ? OffBits - ByteBits : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESP} state_e;

  // PLRU tree stored heap-style: node n (1-based) lives in bit n-1. A bit
  // points to the least-recently-used side of its node (0 = left subtree).
  function automatic logic [WayW-1:0] plru_victim(input logic [PlruW-1:0] b);
    int node;
    node = 1;
    for (int l = 0; l < LogWays; l++) node = 2*node + (b[node-1] ? 1 : 0);
    return WayW'(node - NrWays);
  endfunction

  // Mark a way as most recently used by pointing every node on its path away.
  function automatic logic [PlruW-1:0] plru_touch(input logic [PlruW-1:0] b,
                                                  input logic [WayW-1:0] way);
    logic [PlruW-1:0] nb;
    int node, dir;
    nb   = b;
    node = 1;
    for (int l = 0; l < LogWays; l++) begin
      dir         = (int'(way) >> (LogWays-1-l)) & 1;
      nb[node-1]  = (dir == 0);
      node        = 2*node + dir;
    end
    return nb;
  endfunction

  state_e                           r_state;
  logic [AddrWidth-1:0]             r_addr;
  logic [WayW-1:0]                  r_victim;
  logic [NrSets-1:0][NrWays-1:0]    r_valid;
  logic [NrSets-1:0][PlruW-1:0]     r_plru;
  logic                             r_flush_pend;
  logic [TagBits-1:0]               r_tag  [NrWays][NrSets];
  logic [LineW-1:0]                 r_data [NrWays][NrSets];

  logic [IdxBits-1:0]   w_idx;
  logic [TagBits-1:0]   w_tag;
  logic [WordW-1:0]     w_wsel;
  logic                 w_hit, w_has_inv;
  logic [WayW-1:0]      w_hit_way, w_inv_way, w_victim;
  logic [LineW-1:0]     w_hit_line;
  logic [DataWidth-1:0] w_hit_word, w_fill_word;
  logic                 w_fill, w_install, w_flush_now;

  assign w_idx  = r_addr[OffBits +: IdxBits];
  assign w_tag  = r_addr[AddrWidth-1 -: TagBits];
  assign w_wsel = WordW'((r_addr >> ByteBits) & AddrWidth'(NrWordsPerLine-1));

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = 0; w < NrWays; w++) begin
      if (r_valid[w_idx][w] && (r_tag[w][w_idx] == w_tag) && !w_hit) begin
        w_hit     = 1'b1;
        w_hit_way = WayW'(w);
      end
      // first invalid way wins, so empty ways fill from way 0 upwards
      if (!r_valid[w_idx][w] && !w_has_inv) begin
        w_has_inv = 1'b1;
        w_inv_way = WayW'(w);
      end
    end
  end

  assign w_victim    = w_has_inv ? w_inv_way : plru_victim(r_plru[w_idx]);
  assign w_hit_line  = r_data[w_hit_way][w_idx];
  assign w_hit_word  = w_hit_line[w_wsel*DataWidth +: DataWidth];
  assign w_fill_word = mem_read_data_i[w_wsel*DataWidth +: DataWidth];

  assign w_fill      = (r_state == S_REFILL) && mem_read_valid_i;
  // a flush seen at any point during the miss keeps the stale line out
  assign w_install   = w_fill && !r_flush_pend && !flush_i;
  assign w_flush_now = flush_i || r_flush_pend;
  assign ready_o     = (r_state == S_IDLE) && !flush_i;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_victim      <= '0;
      r_valid       <= '0;
      r_plru        <= '0;
      r_flush_pend  <= 1'b0;
      read_valid_o  <= 1'b0;
      read_word_o   <= '0;
      mem_addr_o    <= '0;
      mem_read_en_o <= 1'b0;
    end else begin
      read_valid_o <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (flush_i) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end else if (read_en_i) begin
            r_addr  <= addr_i;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (flush_i) r_flush_pend <= 1'b1;
          if (w_hit) begin
            read_valid_o         <= 1'b1;
            read_word_o          <= w_hit_word;
            r_plru[w_idx]        <= plru_touch(r_plru[w_idx], w_hit_way);
            r_state              <= S_IDLE;
            if (w_flush_now) begin
              r_valid      <= '0;
              r_flush_pend <= 1'b0;
            end
          end else begin
            r_victim      <= w_victim;
            mem_read_en_o <= 1'b1;
            mem_addr_o    <= {w_tag, w_idx, {OffBits{1'b0}}};
            r_state       <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (flush_i) r_flush_pend <= 1'b1;
          if (mem_read_valid_i) begin
            // word is forwarded straight from the refill bus; RESP is a turnaround
            mem_read_en_o <= 1'b0;
            read_valid_o  <= 1'b1;
            read_word_o   <= w_fill_word;
            r_state       <= S_RESP;
            if (w_install) begin
              r_valid[w_idx][r_victim] <= 1'b1;
              r_plru[w_idx]            <= plru_touch(r_plru[w_idx], r_victim);
            end
          end
        end
        S_RESP: begin
          r_state <= S_IDLE;
          if (w_flush_now) begin
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // tag/data arrays carry no reset; the valid bits qualify them
  always_ff @(posedge clk_i) begin
    if (w_install) begin
      r_tag[r_victim][w_idx]  <= w_tag;
      r_data[r_victim][w_idx] <= mem_read_data_i;
    end
  end

endmodule

// File: tb/tb_icache_setassoc.sv
// Bench for icache_setassoc with the default parameters. A memory responder
// process serves refills with a programmable latency. A monitor pops the
// expected words from a scoreboard queue whenever read_valid_o pulses.
module tb_icache_setassoc;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         flush_i;
  logic [31:0]  addr_i;
  logic         read_en_i;
  logic         ready_o;
  logic         read_valid_o;
  logic [31:0]  read_word_o;
  logic [31:0]  mem_addr_o;
  logic         mem_read_en_o;
  logic         mem_read_valid_i;
  logic [127:0] mem_read_data_i;

  icache_setassoc dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i), .addr_i(addr_i),
    .read_en_i(read_en_i), .ready_o(ready_o), .read_valid_o(read_valid_o),
    .read_word_o(read_word_o), .mem_addr_o(mem_addr_o),
    .mem_read_en_o(mem_read_en_o), .mem_read_valid_i(mem_read_valid_i),
    .mem_read_data_i(mem_read_data_i)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, n_resp = 0, t_resp = 0, n_refill = 0, lat = 0;
  bit flush_in_refill = 0;
  logic [31:0] last_maddr = '0;
  logic [31:0] exp_q[$];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mword(input logic [31:0] la, input int k);
    return (la * 32'h9E37) ^ (32'hC0DE0000 + 32'(k));
  endfunction

  function automatic logic [127:0] mline(input logic [31:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = mword(la, k);
    return l;
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] a);
    return mword(a & 32'hFFFF_FFF0, int'((a >> 2) & 32'd3));
  endfunction

  // memory responder
  initial begin
    logic [31:0] la;
    bit aborted;
    mem_read_valid_i = 1'b0;
    mem_read_data_i  = '0;
    forever begin
      @(negedge clk_i);
      if (rstn_i && mem_read_en_o) begin
        la = mem_addr_o; last_maddr = la; n_refill++; aborted = 0;
        for (int i = 0; i < lat; i++) begin
          if (flush_in_refill) flush_i = (i == 1);
          @(negedge clk_i);
          if (!mem_read_en_o) begin aborted = 1; break; end
          chk("maddr_hold", mem_addr_o, la);
          chk("busy_ready", {31'b0, ready_o}, 32'd0);
        end
        if (flush_in_refill) flush_i = 1'b0;
        if (!aborted) begin
          mem_read_valid_i = 1'b1;
          mem_read_data_i  = mline(la);
          @(negedge clk_i);
          mem_read_valid_i = 1'b0;
          chk("men_drop", {31'b0, mem_read_en_o}, 32'd0);
        end
      end
    end
  end

  // response monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk_i);
      if (read_valid_o) begin
        if (exp_q.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
        else chk("rdata", read_word_o, exp_q.pop_front());
        t_resp = cyc;
        n_resp++;
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input bit miss, input string tag);
    int n0, r0, c0, w;
    @(negedge clk_i);
    w = 0;
    while (!ready_o && w < 100) begin @(negedge clk_i); w++; end
    chk({tag, "_ready"}, {31'b0, ready_o}, 32'd1);
    addr_i = a; read_en_i = 1'b1;
    exp_q.push_back(exp_word(a));
    n0 = n_resp; r0 = n_refill;
    @(posedge clk_i); #1;
    c0 = cyc; read_en_i = 1'b0; addr_i = $urandom;
    w = 0;
    while (n_resp == n0 && w < 100) begin @(negedge clk_i); w++; end
    chk({tag, "_done"}, 32'(n_resp - n0), 32'd1);
    chk({tag, "_miss"}, 32'(n_refill - r0), {31'b0, miss});
    if (miss) chk({tag, "_maddr"}, last_maddr, a & 32'hFFFF_FFF0);
    else chk({tag, "_hitlat"}, 32'(t_resp - c0), 32'd1);
  endtask

  initial begin
    int n0, r0;
    rstn_i = 1'b0; flush_i = 1'b0; addr_i = '0; read_en_i = 1'b0;
    #1;
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_rvalid", {31'b0, read_valid_o}, 32'd0);
    chk("rst_rword", read_word_o, 32'd0);
    chk("rst_men", {31'b0, mem_read_en_o}, 32'd0);
    chk("rst_maddr", mem_addr_o, 32'd0);
    repeat (3) @(negedge clk_i);
    rstn_i = 1'b1;

    // cold miss then hit in the same line
    do_read(32'h1004, 1, "cold");
    do_read(32'h1008, 0, "cold_hit");

    // set 0 conflict with PLRU eviction
    do_read(32'h2000, 1, "c_2000");
    do_read(32'h1000, 0, "c_1000h");
    do_read(32'h3000, 1, "c_3000");
    do_read(32'h1000, 0, "c_1000h2");
    do_read(32'h2000, 1, "c_2000m");

    // a few other sets: miss then hit
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h0000_0150 + 32'(i) * 32'h0000_0410 + 32'(i*4);
      do_read(a, 1, "sets_m");
      do_read(a ^ 32'h4, 0, "sets_h");
    end

    // long memory latency, addr_i toggles during wait, late pulse ignored
    lat = 10;
    do_read(32'h4010, 1, "lat10");
    lat = 0;
    @(negedge clk_i);
    n0 = n_resp;
    mem_read_valid_i = 1'b1; mem_read_data_i = '1;
    @(negedge clk_i);
    mem_read_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("late_pulse_resp", 32'(n_resp - n0), 32'd0);
    chk("late_pulse_men", {31'b0, mem_read_en_o}, 32'd0);
    do_read(32'h4014, 0, "lat10_hit");

    // flush in IDLE wins over a same-cycle request
    @(negedge clk_i);
    n0 = n_resp; r0 = n_refill;
    flush_i = 1'b1; read_en_i = 1'b1; addr_i = 32'h1000;
    #1 chk("flush_ready", {31'b0, ready_o}, 32'd0);
    @(posedge clk_i); #1;
    flush_i = 1'b0; read_en_i = 1'b0;
    repeat (4) @(negedge clk_i);
    chk("flush_noacc", 32'(n_resp - n0), 32'd0);
    chk("flush_norefill", 32'(n_refill - r0), 32'd0);
    do_read(32'h1000, 1, "post_flush");

    // flush during REFILL: data returned, nothing installed
    lat = 3; flush_in_refill = 1;
    do_read(32'h6008, 1, "fl_refill");
    lat = 0; flush_in_refill = 0;
    do_read(32'h1000, 1, "fl_1000");
    do_read(32'h6008, 1, "fl_6008");

    // reset in the middle of a refill
    lat = 8;
    @(negedge clk_i);
    addr_i = 32'h7000; read_en_i = 1'b1;
    @(posedge clk_i); #1;
    read_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("mid_men", {31'b0, mem_read_en_o}, 32'd1);
    rstn_i = 1'b0;
    #1;
    chk("rst_mid_men", {31'b0, mem_read_en_o}, 32'd0);
    chk("rst_mid_ready", {31'b0, ready_o}, 32'd1);
    repeat (2) @(negedge clk_i);
    rstn_i = 1'b1;
    lat = 0;
    do_read(32'h1000, 1, "post_rst");
    do_read(32'h1000, 0, "post_rst_hit");

    repeat (3) @(negedge clk_i);
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
